// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator keypad front end.
// Optional auto-repeat in keypad_scanner is enabled by defining KEYPAD_REPEAT_EN.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
        DEBOUNCE = 3'd2,
        HELD     = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    localparam logic [3:0] COL_IDLE = 4'b1111;

    // Lowest-numbered low row wins so multi-row presses resolve deterministically.
    function automatic logic [3:0] key_code(input logic [3:0] rows, input logic [1:0] c);
        logic [1:0] r;
        casez (rows)
            4'b???0: r = 2'd0;
            4'b??01: r = 2'd1;
            4'b?011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return {r, c};
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Row synchronizer and stable-cycle counter used by keypad_scanner.
// stable rises on the DEBOUNCE_CNT-th consecutive cycle where rs matches ref_code.
module key_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    input  logic       clr,
    input  logic [3:0] ref_code,
    output logic [3:0] rs,
    output logic       stable
);

    localparam int            CW       = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [CW-1:0] cnt_r;
    logic          match_s;

    // Two-flop synchronizer for the asynchronous, pulled-up row lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= COL_IDLE;
            sync2_r <= COL_IDLE;
        end else begin
            sync1_r <= row;
            sync2_r <= sync1_r;
        end
    end

    assign match_s = (sync2_r == ref_code);

    // Saturating count of consecutive matching cycles; any mismatch restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr || !match_s) begin
            cnt_r <= '0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign rs     = sync2_r;
    assign stable = match_s && !clr && (cnt_r >= CNT_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column rotation, debounced press/release, registered key code.
// Define KEYPAD_REPEAT_EN to re-pulse press every REPEAT_DLY cycles while a key is held.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000,
    parameter int REPEAT_DLY   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       press,
    output logic [3:0] numb
);

    localparam int            DW       = $clog2(SCAN_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("SCAN_DIV must be at least 2");
    end
    if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CNT must be at least 1");
    end
    if (REPEAT_DLY < 1) begin : g_bad_repeat
        $error("REPEAT_DLY must be at least 1");
    end

    state_t        state_r;
    logic [3:0]    col_r;
    logic          press_r;
    logic [3:0]    numb_r;
    logic [1:0]    c_r;
    logic [DW-1:0] div_r;
    logic [3:0]    code_r;
    logic [3:0]    rs_s;
    logic          stable_s;
    logic          clr_s;
    logic [3:0]    ref_s;

`ifdef KEYPAD_REPEAT_EN
    localparam int            RW       = $clog2(REPEAT_DLY + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_DLY - 1);
    logic [RW-1:0] rpt_r;
`endif

    // The stable counter only runs while confirming a press or a release.
    assign clr_s = !scan || !((state_r == DEBOUNCE) || (state_r == RELEASE));
    assign ref_s = (state_r == RELEASE) ? COL_IDLE : code_r;

    key_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .clr      (clr_s),
        .ref_code (ref_s),
        .rs       (rs_s),
        .stable   (stable_s)
    );

    // Scanner FSM with registered column drive, press strobe and key code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            col_r   <= COL_IDLE;
            press_r <= 1'b0;
            numb_r  <= 4'h0;
            c_r     <= 2'd0;
            div_r   <= '0;
            code_r  <= COL_IDLE;
`ifdef KEYPAD_REPEAT_EN
            rpt_r   <= '0;
`endif
        end else begin
            press_r <= 1'b0;
            if (!scan) begin
                // Dropping scan beats any pending press; numb keeps its value.
                state_r <= IDLE;
                col_r   <= COL_IDLE;
                c_r     <= 2'd0;
                div_r   <= '0;
`ifdef KEYPAD_REPEAT_EN
                rpt_r   <= '0;
`endif
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= SCAN;
                        col_r   <= col_drive(c_r);
                        div_r   <= '0;
                    end
                    SCAN: begin
                        if (rs_s != COL_IDLE) begin
                            state_r <= DEBOUNCE;
                            code_r  <= rs_s;
                            div_r   <= '0;
                        end else if (div_r == DIV_LAST) begin
                            div_r <= '0;
                            c_r   <= c_r + 2'd1;
                            col_r <= col_drive(c_r + 2'd1);
                        end else begin
                            div_r <= div_r + DW'(1);
                        end
                    end
                    DEBOUNCE: begin
                        if (rs_s != code_r) begin
                            state_r <= SCAN;
                        end else if (stable_s) begin
                            state_r <= HELD;
                            press_r <= 1'b1;
                            numb_r  <= key_code(code_r, c_r);
`ifdef KEYPAD_REPEAT_EN
                            rpt_r   <= '0;
`endif
                        end else begin
                            state_r <= DEBOUNCE;
                        end
                    end
                    HELD: begin
                        if (rs_s == COL_IDLE) begin
                            state_r <= RELEASE;
`ifdef KEYPAD_REPEAT_EN
                            rpt_r   <= '0;
                        end else if (rpt_r == RPT_LAST) begin
                            press_r <= 1'b1;
                            rpt_r   <= '0;
                        end else begin
                            rpt_r   <= rpt_r + RW'(1);
`else
                        end else begin
                            state_r <= HELD;
`endif
                        end
                    end
                    RELEASE: begin
                        if (rs_s != COL_IDLE) begin
                            state_r <= HELD;
                        end else if (stable_s) begin
                            state_r <= SCAN;
                            div_r   <= '0;
                        end else begin
                            state_r <= RELEASE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        col_r   <= COL_IDLE;
                    end
                endcase
            end
        end
    end

    assign col   = col_r;
    assign press = press_r;
    assign numb  = numb_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_DLY=20).
// Expected repeat behaviour follows KEYPAD_REPEAT_EN when defined for the build.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic       scan;
    logic [3:0] row;
    logic [3:0] col;
    logic       press;
    logic [3:0] numb;

    logic       key_on;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic       bounce_on;
    logic [3:0] bounce_row;

    int checks;
    int failures;
    int press_cnt;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8),
        .REPEAT_DLY   (20)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .scan  (scan),
        .row   (row),
        .col   (col),
        .press (press),
        .numb  (numb)
    );

    // Keypad matrix model: a held key pulls its row low only while its column is driven.
    assign row = bounce_on ? bounce_row :
                 ((key_on && (col == key_col)) ? key_row : 4'b1111);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press === 1'b1) press_cnt <= press_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_col(input string tag, input logic [3:0] target, input int budget);
        int n;
        n = 0;
        while (col !== target && n < budget) begin
            tick();
            n++;
        end
        check(tag, col, target);
    endtask

    task automatic next_col(input string tag, input logic [3:0] exp);
        logic [3:0] prev;
        int n;
        prev = col;
        n = 0;
        do begin
            tick();
            n++;
        end while (col === prev && n < 10);
        check(tag, col, exp);
    endtask

    task automatic wait_press(input string tag, input int budget);
        int start;
        int n;
        start = press_cnt;
        n = 0;
        while (press_cnt == start && n < budget) begin
            tick();
            n++;
        end
        check(tag, press_cnt, start + 1);
    endtask

    initial begin
        int base;
        int early;
        int nrep;
        int offs [4];

        checks = 0;
        failures = 0;
        press_cnt = 0;
        rst = 1'b0;
        scan = 1'b0;
        key_on = 1'b0;
        key_col = 4'b1111;
        key_row = 4'b1111;
        bounce_on = 1'b0;
        bounce_row = 4'b1111;
        for (int i = 0; i < 4; i++) offs[i] = 0;

        // Reset state
        ticks(3);
        check("rst_col", col, 4'b1111);
        check("rst_press", press, 1'b0);
        check("rst_numb", numb, 4'h0);
        rst = 1'b1;
        ticks(3);
        check("idle_col", col, 4'b1111);
        scan = 1'b1;
        tick();
        check("scan_start_col0", col, 4'b1110);

        // Single press r=2 c=1 lands exactly 11 cycles after its column is driven
        base = press_cnt;
        key_col = 4'b1101;
        key_row = 4'b1011;
        key_on = 1'b1;
        wait_col("p29_reach_col1", 4'b1101, 20);
        early = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (press === 1'b1) early++;
        end
        check("p29_no_early_press", early, 0);
        tick();
        check("p29_press_pulse", press, 1'b1);
        check("p29_numb", numb, 4'h9);
        tick();
        check("p29_press_one_cycle", press, 1'b0);
        ticks(10);
        check("p29_col_frozen", col, 4'b1101);
        check("p29_single_press", press_cnt, base + 1);
        key_on = 1'b0;
        wait_col("p29_rotation_after_release", 4'b1011, 40);
        check("p29_no_release_press", press_cnt, base + 1);

        // Bouncing contact never completes debounce
        base = press_cnt;
        for (int k = 0; k < 4; k++) begin
            bounce_on = 1'b1;
            bounce_row = 4'b1110;
            ticks(5);
            bounce_on = 1'b0;
            ticks(5);
        end
        ticks(12);
        check("p30_bounce_no_press", press_cnt, base);
        check("p30_numb_held", numb, 4'h9);
        wait_col("p30_col1", 4'b1101, 40);
        next_col("p30_col2", 4'b1011);
        next_col("p30_col3", 4'b0111);
        next_col("p30_col0", 4'b1110);

        // Multi-row press on column 3: row 0 wins; re-press gives a second press
        base = press_cnt;
        key_col = 4'b0111;
        key_row = 4'b0110;
        key_on = 1'b1;
        wait_press("p31_first_press", 60);
        check("p31_numb", numb, 4'h3);
        key_on = 1'b0;
        ticks(30);
        check("p31_one_press", press_cnt, base + 1);
        key_on = 1'b1;
        wait_press("p31_second_press", 60);
        check("p31_numb_again", numb, 4'h3);
        key_on = 1'b0;
        ticks(30);
        check("p31_two_presses", press_cnt, base + 2);

        // scan drops on the cycle the press would be issued
        scan = 1'b0;
        ticks(2);
        base = press_cnt;
        key_col = 4'b1110;
        key_row = 4'b0111;
        key_on = 1'b1;
        scan = 1'b1;
        wait_col("p32_reach_col0", 4'b1110, 5);
        ticks(10);
        scan = 1'b0;
        tick();
        check("p32_press_suppressed", press, 1'b0);
        check("p32_col_idle", col, 4'b1111);
        check("p32_numb_kept", numb, 4'h3);
        ticks(5);
        check("p32_no_press_count", press_cnt, base);
        key_on = 1'b0;

        // Asynchronous reset while HELD
        key_col = 4'b1110;
        key_row = 4'b1101;
        key_on = 1'b1;
        scan = 1'b1;
        wait_press("p33_press", 40);
        check("p33_numb", numb, 4'h4);
        ticks(3);
        rst = 1'b0;
        #1;
        check("p33_async_col", col, 4'b1111);
        check("p33_async_press", press, 1'b0);
        check("p33_async_numb", numb, 4'h0);
        tick();
        base = press_cnt;
        rst = 1'b1;
        ticks(10);
        check("p33_no_press_after_reset", press_cnt, base);
        wait_press("p33_fresh_press", 40);
        check("p33_fresh_numb", numb, 4'h4);
        key_on = 1'b0;
        ticks(30);

        // Held key F: repeat pulses only with auto-repeat enabled
        key_col = 4'b0111;
        key_row = 4'b0111;
        key_on = 1'b1;
        wait_press("p34_first_press", 60);
        check("p34_numb", numb, 4'hF);
        nrep = 0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (press === 1'b1) begin
                if (nrep < 4) offs[nrep] = i;
                nrep++;
            end
        end
        check("p34_numb_held", numb, 4'hF);
`ifdef KEYPAD_REPEAT_EN
        check("p34_repeat_count", nrep, 3);
        check("p34_repeat_1", offs[0], 20);
        check("p34_repeat_2", offs[1], 40);
        check("p34_repeat_3", offs[2], 60);
`else
        check("p34_repeat_count", nrep, 0);
`endif
        key_on = 1'b0;
        ticks(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each column stays driven while scanning (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 50000: consecutive stable cycles required to accept a press or a release (minimum 1).
REQ-003 SHALL have parameter REPEAT_DLY, default 25000000: held-key cycles between auto-repeat pulses; used only with KEYPAD_REPEAT_EN.
REQ-004 SHALL have port clk  input  1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port scan  input  1: scan enable driven by the calculator controller.
REQ-007 SHALL have port row  input  4: keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-008 SHALL have port col  output  4: keypad column drive, one-hot active-low; 4'b1111 means idle.
REQ-009 SHALL have port press  output  1: single-cycle key-accepted strobe.
REQ-010 SHALL have port numb  output  4: code of the last accepted key, held between presses.

Function
REQ-011 SHALL pass row through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-012 SHALL implement FSM states IDLE, SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 IDLE: col=4'b1111; enter SCAN the cycle after scan=1.
REQ-014 SCAN: drive column index c (0..3) low; advance c = c+1 mod 4 every SCAN_DIV cycles (3 wraps to 0); enter DEBOUNCE when rs != 4'b1111, freezing c.
REQ-015 DEBOUNCE: count cycles with rs equal to the captured row code; if rs changes or returns to 4'b1111, clear the count and return to SCAN without emitting press.
REQ-016 Once DEBOUNCE_CNT stable cycles elapse, SHALL pulse press high for exactly one cycle, load numb in that same cycle, and enter HELD.
REQ-017 Key code SHALL be numb = {r[1:0], c[1:0]}, where r is the index of the lowest-numbered low row bit (multi-row presses resolve to the lowest row).
REQ-018 HELD: keep column c driven; enter RELEASE when rs = 4'b1111.
REQ-019 RELEASE: return to SCAN after DEBOUNCE_CNT consecutive cycles with rs = 4'b1111; any low rs bit returns to HELD with the count cleared and no new press.
REQ-020 When scan=0 in any state, SHALL enter IDLE next cycle and clear all counters; press SHALL not assert; numb SHALL hold.
REQ-021 If scan falls in the same cycle that press would assert, scan SHALL win: no press is emitted.
REQ-022 Counters SHALL be sized $clog2(param+1) and SHALL saturate, never wrap.

Reset
REQ-023 When rst=0, SHALL asynchronously force state=IDLE, col=4'b1111, press=0, numb=4'h0, c=0, all counters=0, and synchronizer=4'b1111.
REQ-024 Reset asserted mid-debounce or while HELD SHALL discard the pending key; no press follows reset release until a fresh debounce completes.

Configuration
REQ-025 With KEYPAD_REPEAT_EN defined, HELD SHALL re-pulse press with the same numb every REPEAT_DLY cycles while the key stays down, with the first repeat REPEAT_DLY cycles after the initial press.
REQ-026 Without KEYPAD_REPEAT_EN, exactly one press SHALL occur per physical press; the repeat counter SHALL not exist.

Structure
REQ-027 Package calc_pkg SHALL hold the FSM state enum, COL_IDLE=4'b1111, and the key-code helper.
REQ-028 The 2-flop synchronizer plus stable-count logic SHALL be sub-module key_debounce; FSM and column drive SHALL stay in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_DLY=20)
REQ-029 Hold row=4'b1011 while col=4'b1101 (r=2, c=1) -> exactly one press, numb=4'h9; col frozen at 4'b1101 until release.
REQ-030 Bounce row low for 5 cycles then high, repeated -> no press; column rotation resumes 1101->1011->0111->1110.
REQ-031 row=4'b0110 on column 3 -> numb=4'h3 (row 0 wins); release then re-press -> second single press.
REQ-032 Deassert scan on the cycle press is due -> press stays 0, col=4'b1111 next cycle, numb unchanged.
REQ-033 Assert rst=0 during HELD -> immediate col=4'b1111, press=0, numb=4'h0 without a clk edge.
REQ-034 With KEYPAD_REPEAT_EN, hold key 4'hF for 70 cycles after first press -> press at +0, +20, +40, +60; without the macro -> one press.
